// File: rtl/pad_reader_pkg.sv
// Shared types and constants for the NES-style gamepad reader.
// Button indices follow the controller's serial shift order.
package pad_reader_pkg;

  localparam int PAD_BITS   = 8;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef struct packed {
    logic right;
    logic left;
    logic jump;
    logic squat;
    logic defend;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} pad_state_t;

endpackage

// File: rtl/pad_reader_sync_bit.sv
// Multi-flop synchroniser for the asynchronous pad_data line.
// Resets to 1 so that a released (high) line reads as "not pressed".
module sync_bit
  import pad_reader_pkg::*;
#(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STG-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STG-2:0], d};
    end
  end

  assign q = r_chain[STG-1];

endmodule

// File: rtl/pad_reader.sv
// Gamepad front end: polls a 4021 shift-register pad and drives per-player commands.
// Define PAD_DEBOUNCE_EN to require two identical consecutive reads before publishing.
module pad_reader
  import pad_reader_pkg::*;
#(
  parameter int HALF_CYC = 6,
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic poll,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic right,
  output logic left,
  output logic jump,
  output logic squat,
  output logic defend,
  output logic upd,
  output logic busy
);

  localparam int CNT_W = $clog2(2*HALF_CYC+1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2*HALF_CYC-1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC-1);

  pad_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_bit;
  logic [PAD_BITS-1:0] r_btn;
  cmd_t                r_cmd;
  logic                r_latch;
  logic                r_pclk;
  logic                r_upd;
  logic                r_busy;
  logic                w_data_sync;
  cmd_t                w_mapped;
`ifdef PAD_DEBOUNCE_EN
  cmd_t                r_prev;
`endif

  function automatic cmd_t map_buttons(input logic [PAD_BITS-1:0] btn);
    cmd_t c;
    logic jump_raw;
    jump_raw = btn[BTN_UP] | btn[BTN_A];
    c.right  = btn[BTN_RIGHT] & ~btn[BTN_LEFT];
    c.left   = btn[BTN_LEFT] & ~btn[BTN_RIGHT];
    c.jump   = jump_raw;
    c.squat  = btn[BTN_DOWN] & ~jump_raw;
    c.defend = btn[BTN_B];
    return c;
  endfunction

  sync_bit #(.STG(SYNC_STG)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_data),
    .q     (w_data_sync)
  );

  assign w_mapped = map_buttons(r_btn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_btn   <= '0;
      r_cmd   <= '0;
      r_latch <= 1'b0;
      r_pclk  <= 1'b1;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      r_prev  <= '0;
`endif
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (poll) begin
            r_state <= LATCH;
            r_latch <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        LATCH: begin
          if (r_cnt == LATCH_LAST) begin
            r_state <= LOW;
            r_latch <= 1'b0;
            r_pclk  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        LOW: begin
          // Sample at the end of the low phase, long after the last shift settled.
          if (r_cnt == HALF_LAST) begin
            r_btn[r_bit] <= ~w_data_sync;
            r_state      <= HIGH;
            r_pclk       <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= DONE;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_state <= LOW;
              r_pclk  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
          r_prev <= w_mapped;
          if ((w_mapped == r_prev) && (w_mapped != r_cmd)) begin
            r_cmd <= w_mapped;
            r_upd <= 1'b1;
          end
`else
          r_cmd <= w_mapped;
          r_upd <= 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pad_latch = r_latch;
  assign pad_clk   = r_pclk;
  assign right     = r_cmd.right;
  assign left      = r_cmd.left;
  assign jump      = r_cmd.jump;
  assign squat     = r_cmd.squat;
  assign defend    = r_cmd.defend;
  assign upd       = r_upd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader with a behavioural 4021 controller and an upd scoreboard.
// Also builds with PAD_DEBOUNCE_EN defined (each vector is then polled twice).
module tb_pad_reader;
  import pad_reader_pkg::*;

  localparam int HC  = 6;
  localparam int LAT = 1 + 2*HC + 16*HC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic poll = 1'b0;
  logic pad_data;
  logic pad_latch, pad_clk, right, left, jump, squat, defend, upd, busy;

  pad_reader #(.HALF_CYC(HC), .SYNC_STG(2)) dut (
    .clk(clk), .rst_n(rst_n), .poll(poll), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .right(right), .left(left),
    .jump(jump), .squat(squat), .defend(defend), .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  // 4021 model: parallel load while latched, shift toward Q on rising pad_clk.
  logic [7:0] pressed = 8'h00;
  logic [7:0] sr = 8'hFF;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) sr = ~pressed;
    else           sr = {1'b1, sr[7:1]};
  end
  assign #2 pad_data = sr[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    cmd_t cmd;
    int   at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] btns;
    cmd_t       exp;
  } vec_t;
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int latch_hi = 0;
  int pclk_falls = 0;
  logic prev_pclk = 1'b1;

  function automatic cmd_t cur_cmd();
    return {right, left, jump, squat, defend};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of observation: pulse counters plus the upd scoreboard.
  task automatic tick();
    cmd_t a;
    exp_t e;
    @(negedge clk);
    if (pad_latch) latch_hi++;
    if (prev_pclk && !pad_clk) pclk_falls++;
    prev_pclk = pad_clk;
    if (upd) begin
      upd_cnt++;
      a = cur_cmd();
      $display("upd cyc=%0d cmd(r,l,j,s,d)=%05b", cyc, a);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd: got upd=1 expected none (cyc %0d cmd %05b)", cyc, a);
      end else begin
        e = sb.pop_front();
        chk("upd_cmd", 32'(a), 32'(e.cmd));
        chk("upd_cycle", cyc, e.at);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("busy_timeout", 32'(busy), 0);
  endtask

  task automatic do_poll(input logic [7:0] btns, input logic exp_upd, input cmd_t exp);
    int l0, f0;
    pressed = btns;
    l0 = latch_hi;
    f0 = pclk_falls;
    poll = 1'b1;
    if (exp_upd) sb.push_back('{exp, cyc + LAT});
    tick();
    poll = 1'b0;
    chk("busy_after_poll", 32'(busy), 1);
    wait_idle();
    tick();
    chk("latch_cycles", latch_hi - l0, 2*HC);
    chk("pad_clk_pulses", pclk_falls - f0, 8);
  endtask

  initial begin
    int u0, f0, n;
    vecs[0] = '{8'h80, cmd_t'(5'b10000)};  // Right
    vecs[1] = '{8'hC2, cmd_t'(5'b00001)};  // Left+Right+B
    vecs[2] = '{8'h21, cmd_t'(5'b00100)};  // Down+A
    vecs[3] = '{8'h20, cmd_t'(5'b00010)};  // Down
    vecs[4] = '{8'h40, cmd_t'(5'b01000)};  // Left
    vecs[5] = '{8'h34, cmd_t'(5'b00100)};  // Up+Down+Select
    vecs[6] = '{8'h0C, cmd_t'(5'b00000)};  // Select+Start
    vecs[7] = '{8'h52, cmd_t'(5'b01101)};  // B+Left+Up

    // Reset state and 200 idle cycles
    repeat (3) tick();
    chk("rst_latch", 32'(pad_latch), 0);
    chk("rst_pad_clk", 32'(pad_clk), 1);
    chk("rst_cmd", 32'(cur_cmd()), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (200) tick();
    chk("idle_upd_cnt", upd_cnt, 0);
    chk("idle_latch", 32'(pad_latch), 0);
    chk("idle_pad_clk", 32'(pad_clk), 1);
    chk("idle_cmd", 32'(cur_cmd()), 0);

    // Mapping table
    for (int i = 0; i < 8; i++) begin
`ifdef PAD_DEBOUNCE_EN
      do_poll(vecs[i].btns, 1'b0, '0);
      chk("deb_first_read_held", 32'(cur_cmd()), (i == 0) ? 32'd0 : 32'(vecs[i-1].exp));
`endif
      do_poll(vecs[i].btns, 1'b1, vecs[i].exp);
      chk("vec_cmd", 32'(cur_cmd()), 32'(vecs[i].exp));
      $display("vec %0d btns=%02h cmd=%05b", i, vecs[i].btns, cur_cmd());
    end

    // Second poll 40 cycles into a read is ignored
    u0 = upd_cnt;
    pressed = 8'h52;
    poll = 1'b1;
`ifndef PAD_DEBOUNCE_EN
    sb.push_back('{cmd_t'(5'b01101), cyc + LAT});
`endif
    tick();
    poll = 1'b0;
    repeat (39) tick();
    poll = 1'b1;
    tick();
    poll = 1'b0;
    wait_idle();
    repeat (20) tick();
`ifdef PAD_DEBOUNCE_EN
    chk("ignored_poll_upds", upd_cnt - u0, 0);
`else
    chk("ignored_poll_upds", upd_cnt - u0, 1);
`endif
    chk("ignored_poll_busy", 32'(busy), 0);

    // Reset during the LOW phase of bit 4
    f0 = pclk_falls;
    poll = 1'b1;
    tick();
    poll = 1'b0;
    n = 0;
    while ((pclk_falls - f0) < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("bit4_reached", 32'(pclk_falls - f0), 5);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_latch", 32'(pad_latch), 0);
    chk("abort_pad_clk", 32'(pad_clk), 1);
    chk("abort_cmd", 32'(cur_cmd()), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_upd", 32'(upd), 0);
    u0 = upd_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (150) tick();
    chk("abort_no_upd", upd_cnt - u0, 0);
`ifdef PAD_DEBOUNCE_EN
    do_poll(8'h52, 1'b0, '0);
`endif
    do_poll(8'h52, 1'b1, cmd_t'(5'b01101));
    chk("post_abort_cmd", 32'(cur_cmd()), 32'(5'b01101));

`ifdef PAD_DEBOUNCE_EN
    // Debounce: alternating reads never publish, two matching reads do
    u0 = upd_cnt;
    do_poll(8'h80, 1'b0, '0);
    do_poll(8'h00, 1'b0, '0);
    do_poll(8'h80, 1'b0, '0);
    chk("deb_right_held_0", 32'(right), 0);
    do_poll(8'h80, 1'b1, cmd_t'(5'b10000));
    chk("deb_right_1", 32'(right), 1);
    chk("deb_single_upd", upd_cnt - u0, 1);
`endif

    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
